// File: rtl/mips_defs_pkg.sv
// Shared MIPS decode definitions: ALU op_codes, opcode/funct values and
// the control bundle carried from decode into execute.
package mips_defs_pkg;

    localparam int unsigned ALU_OP_W   = 4;
    localparam int unsigned OPCODE_W   = 6;
    localparam int unsigned FUNCT_W    = 6;
    localparam int unsigned IMM_W      = 16;
    localparam int unsigned LUI_SHIFT  = 16;

    localparam logic [ALU_OP_W-1:0] ALU_SLL = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SRL = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_SRA = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_NOR = 4'd8;
    localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'd9;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPCODE_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPCODE_W-1:0] OP_ADDIU = 6'h09;
    localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OPCODE_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OPCODE_W-1:0] OP_XORI  = 6'h0E;
    localparam logic [OPCODE_W-1:0] OP_LUI   = 6'h0F;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

    localparam logic [FUNCT_W-1:0] FN_SLL  = 6'h00;
    localparam logic [FUNCT_W-1:0] FN_SRL  = 6'h02;
    localparam logic [FUNCT_W-1:0] FN_SRA  = 6'h03;
    localparam logic [FUNCT_W-1:0] FN_SLLV = 6'h04;
    localparam logic [FUNCT_W-1:0] FN_SRLV = 6'h06;
    localparam logic [FUNCT_W-1:0] FN_SRAV = 6'h07;
    localparam logic [FUNCT_W-1:0] FN_ADD  = 6'h20;
    localparam logic [FUNCT_W-1:0] FN_ADDU = 6'h21;
    localparam logic [FUNCT_W-1:0] FN_SUB  = 6'h22;
    localparam logic [FUNCT_W-1:0] FN_SUBU = 6'h23;
    localparam logic [FUNCT_W-1:0] FN_AND  = 6'h24;
    localparam logic [FUNCT_W-1:0] FN_OR   = 6'h25;
    localparam logic [FUNCT_W-1:0] FN_XOR  = 6'h26;
    localparam logic [FUNCT_W-1:0] FN_NOR  = 6'h27;
    localparam logic [FUNCT_W-1:0] FN_SLT  = 6'h2A;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch_eq;
        logic branch_ne;
    } ctrl_t;

    typedef enum logic [1:0] {
        OP1_RS    = 2'd0,
        OP1_SHAMT = 2'd1,
        OP1_LUI   = 2'd2
    } op1_sel_t;

    typedef enum logic {
        OP2_RT  = 1'b0,
        OP2_IMM = 1'b1
    } op2_sel_t;

    typedef enum logic {
        EXT_SIGN = 1'b0,
        EXT_ZERO = 1'b1
    } ext_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational opcode/funct decode into ALU op, operand selects,
// immediate extension mode, control bits and an illegal flag.
module alu_decoder
    import mips_defs_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNCT_W-1:0]  funct,
    output logic [ALU_OP_W-1:0] alu_op_c,
    output op1_sel_t            op1_sel_c,
    output op2_sel_t            op2_sel_c,
    output ext_t                ext_c,
    output logic                dest_rd_c,
    output ctrl_t               ctrl_c,
    output logic                illegal_c
);

    always_comb begin
        alu_op_c  = ALU_SLL;
        op1_sel_c = OP1_RS;
        op2_sel_c = OP2_RT;
        ext_c     = EXT_SIGN;
        dest_rd_c = 1'b0;
        ctrl_c    = '0;
        illegal_c = 1'b0;

        unique case (opcode)
            OP_RTYPE: begin
                dest_rd_c        = 1'b1;
                ctrl_c.reg_write = 1'b1;
                unique case (funct)
                    FN_SLL:  begin alu_op_c = ALU_SLL; op1_sel_c = OP1_SHAMT; end
                    FN_SRL:  begin alu_op_c = ALU_SRL; op1_sel_c = OP1_SHAMT; end
                    FN_SRA:  begin alu_op_c = ALU_SRA; op1_sel_c = OP1_SHAMT; end
                    FN_SLLV: alu_op_c = ALU_SLL;
                    FN_SRLV: alu_op_c = ALU_SRL;
                    FN_SRAV: alu_op_c = ALU_SRA;
                    FN_ADD, FN_ADDU: alu_op_c = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_op_c = ALU_SUB;
                    FN_AND:  alu_op_c = ALU_AND;
                    FN_OR:   alu_op_c = ALU_OR;
                    FN_XOR:  alu_op_c = ALU_XOR;
                    FN_NOR:  alu_op_c = ALU_NOR;
                    FN_SLT:  alu_op_c = ALU_SLT;
                    default: illegal_c = 1'b1;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                alu_op_c = ALU_ADD; op2_sel_c = OP2_IMM; ctrl_c.reg_write = 1'b1;
            end
            OP_SLTI: begin
                alu_op_c = ALU_SLT; op2_sel_c = OP2_IMM; ctrl_c.reg_write = 1'b1;
            end
            OP_ANDI: begin
                alu_op_c = ALU_AND; op2_sel_c = OP2_IMM; ext_c = EXT_ZERO;
                ctrl_c.reg_write = 1'b1;
            end
            OP_ORI: begin
                alu_op_c = ALU_OR; op2_sel_c = OP2_IMM; ext_c = EXT_ZERO;
                ctrl_c.reg_write = 1'b1;
            end
            OP_XORI: begin
                alu_op_c = ALU_XOR; op2_sel_c = OP2_IMM; ext_c = EXT_ZERO;
                ctrl_c.reg_write = 1'b1;
            end
            // LUI is realised as imm << 16 on the shifter
            OP_LUI: begin
                alu_op_c = ALU_SLL; op1_sel_c = OP1_LUI; op2_sel_c = OP2_IMM;
                ext_c = EXT_ZERO; ctrl_c.reg_write = 1'b1;
            end
            OP_LW: begin
                alu_op_c = ALU_ADD; op2_sel_c = OP2_IMM;
                ctrl_c.reg_write = 1'b1; ctrl_c.mem_read = 1'b1;
            end
            OP_SW: begin
                alu_op_c = ALU_ADD; op2_sel_c = OP2_IMM; ctrl_c.mem_write = 1'b1;
            end
            OP_BEQ: begin
                alu_op_c = ALU_SUB; ctrl_c.branch_eq = 1'b1;
            end
            OP_BNE: begin
                alu_op_c = ALU_SUB; ctrl_c.branch_ne = 1'b1;
            end
            default: illegal_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes the instruction, pre-muxes ALU operands
// and registers them with control bits under flush/stall control.
module id_ex_stage
    import mips_defs_pkg::*;
#(
    parameter int unsigned N          = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           instr,
    input  logic                  instr_valid,
    input  logic [N-1:0]          rs_data,
    input  logic [N-1:0]          rt_data,
    input  logic                  stall,
    input  logic                  flush,
    output logic [3:0]            alu_op,
    output logic [N-1:0]          alu_operand1,
    output logic [N-1:0]          alu_operand2,
    output logic [N-1:0]          store_data,
    output logic [REG_ADDR_W-1:0] dest_reg,
    output logic                  reg_write,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  branch_eq,
    output logic                  branch_ne,
    output logic                  ex_valid,
    output logic                  illegal
);

    logic [ALU_OP_W-1:0]   alu_op_c;
    op1_sel_t              op1_sel_c;
    op2_sel_t              op2_sel_c;
    ext_t                  ext_c;
    logic                  dest_rd_c;
    ctrl_t                 ctrl_c;
    logic                  illegal_c;

    logic [N-1:0]          imm_ext;
    logic [ALU_OP_W-1:0]   nxt_alu_op;
    logic [N-1:0]          nxt_op1;
    logic [N-1:0]          nxt_op2;
    logic [N-1:0]          nxt_store;
    logic [REG_ADDR_W-1:0] nxt_dest;
    ctrl_t                 nxt_ctrl;
    logic                  nxt_valid;
    logic                  nxt_illegal;

    // rs address field is consumed by the register file, not here
    logic unused_rs_addr;
    assign unused_rs_addr = ^instr[25:21];

    alu_decoder u_alu_decoder (
        .opcode    (instr[31:26]),
        .funct     (instr[5:0]),
        .alu_op_c  (alu_op_c),
        .op1_sel_c (op1_sel_c),
        .op2_sel_c (op2_sel_c),
        .ext_c     (ext_c),
        .dest_rd_c (dest_rd_c),
        .ctrl_c    (ctrl_c),
        .illegal_c (illegal_c)
    );

    // Operand muxing; bubbles (invalid or illegal slots) load all zeros
    always_comb begin
        nxt_alu_op  = '0;
        nxt_op1     = '0;
        nxt_op2     = '0;
        nxt_store   = '0;
        nxt_dest    = '0;
        nxt_ctrl    = '0;
        nxt_valid   = 1'b0;
        nxt_illegal = instr_valid & illegal_c;

        if (ext_c == EXT_SIGN) begin
            imm_ext = {{(N-IMM_W){instr[15]}}, instr[15:0]};
        end else begin
            imm_ext = {{(N-IMM_W){1'b0}}, instr[15:0]};
        end

        if (instr_valid && !illegal_c) begin
            nxt_alu_op = alu_op_c;
            unique case (op1_sel_c)
                OP1_SHAMT: nxt_op1 = N'(instr[10:6]);
                OP1_LUI:   nxt_op1 = N'(LUI_SHIFT);
                default:   nxt_op1 = rs_data;
            endcase
            nxt_op2   = (op2_sel_c == OP2_IMM) ? imm_ext : rt_data;
            nxt_store = rt_data;
            nxt_dest  = dest_rd_c ? REG_ADDR_W'(instr[15:11]) : REG_ADDR_W'(instr[20:16]);
            nxt_ctrl  = ctrl_c;
            nxt_valid = 1'b1;
        end
    end

    // Priority: reset, flush, stall (hold all but illegal), load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op       <= '0;
            alu_operand1 <= '0;
            alu_operand2 <= '0;
            store_data   <= '0;
            dest_reg     <= '0;
            reg_write    <= 1'b0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            branch_eq    <= 1'b0;
            branch_ne    <= 1'b0;
            ex_valid     <= 1'b0;
            illegal      <= 1'b0;
        end else if (flush) begin
            alu_op       <= '0;
            alu_operand1 <= '0;
            alu_operand2 <= '0;
            store_data   <= '0;
            dest_reg     <= '0;
            reg_write    <= 1'b0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            branch_eq    <= 1'b0;
            branch_ne    <= 1'b0;
            ex_valid     <= 1'b0;
            illegal      <= 1'b0;
        end else if (stall) begin
            illegal      <= 1'b0;
        end else begin
            alu_op       <= nxt_alu_op;
            alu_operand1 <= nxt_op1;
            alu_operand2 <= nxt_op2;
            store_data   <= nxt_store;
            dest_reg     <= nxt_dest;
            reg_write    <= nxt_ctrl.reg_write;
            mem_read     <= nxt_ctrl.mem_read;
            mem_write    <= nxt_ctrl.mem_write;
            branch_eq    <= nxt_ctrl.branch_eq;
            branch_ne    <= nxt_ctrl.branch_ne;
            ex_valid     <= nxt_valid;
            illegal      <= nxt_illegal;
        end
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between instruction decode and the execute-stage ALU.
- Decodes the MIPS opcode and funct fields into the 4-bit ALU op_code.
- Selects and extends the ALU operands, then registers them together with the write-back and memory control bits.
- Supports stall (hold) and flush (bubble) from the hazard unit, so the ALU always sees a stable, pre-muxed operand pair.

Parameters:
- N, 32, datapath width of register operands and ALU operands.
- REG_ADDR_W, 5, register-file address width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset: one clock; reset is asynchronous and active-low.
- instr  input  32  instruction word from IF/ID
- instr_valid  input  1  instr is a real instruction, not a bubble
- rs_data  input  N  register file read data, port A (rs)
- rt_data  input  N  register file read data, port B (rt)
- stall  input  1  hold all outputs this cycle
- flush  input  1  replace the next registered instruction with a bubble
- alu_op  output  4  ALU op_code: 0 SLL, 1 SRL, 2 SRA, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR, 8 NOR, 9 SLT
- alu_operand1  output  N  ALU operand1; for shifts, bits [4:0] give the shift amount
- alu_operand2  output  N  ALU operand2; for shifts, the value being shifted
- store_data  output  N  rt_data, carried forward for SW
- dest_reg  output  REG_ADDR_W  write-back register address
- reg_write  output  1  write-back enable
- mem_read  output  1  load
- mem_write  output  1  store
- branch_eq  output  1  BEQ
- branch_ne  output  1  BNE
- ex_valid  output  1  the registered slot holds a valid instruction
- illegal  output  1  one-cycle pulse: the unsupported opcode/funct just registered

Behaviour:
- Reset (async, rst_n=0): every output is 0. alu_op=0 is harmless because ex_valid=0.
- Latency: exactly 1 cycle. Combinational decode of instr; all outputs are registered on the rising clk edge.
- Update priority on each edge: rst_n low, then flush, then stall, then normal load.
  - flush=1: load a bubble (all outputs 0), including when stall=1 in the same cycle.
  - stall=1, flush=0: all outputs hold their previous values, except illegal, which goes to 0.
  - Normal load, instr_valid=0: load a bubble.
- R-type decode (opcode 0x00), by funct:
  - 0x00/0x02/0x03 (SLL/SRL/SRA): alu_op=0/1/2; operand1 = zero-extended instr[10:6]; operand2 = rt_data.
  - 0x04/0x06/0x07 (SLLV/SRLV/SRAV): alu_op=0/1/2; operand1 = rs_data; operand2 = rt_data.
  - 0x20/0x21 ADD/ADDU: alu_op=3. 0x22/0x23 SUB/SUBU: alu_op=4.
  - 0x24 AND: 5. 0x25 OR: 6. 0x26 XOR: 7. 0x27 NOR: 8. 0x2A SLT: 9.
  - For the non-shift R-type ops: operand1 = rs_data, operand2 = rt_data.
  - dest_reg = instr[15:11]; reg_write=1.
  - A dest_reg of 0 is still written; register $0 protection lives in the register file.
- I-type decode:
  - operand1 = rs_data (LUI excepted); dest_reg = instr[20:16].
  - Sign-extended immediate: ADDI/ADDIU (0x08/0x09) give ADD; SLTI (0x0A) gives SLT.
  - Zero-extended immediate: ANDI (0x0C) gives AND; ORI (0x0D) gives OR; XORI (0x0E) gives XOR.
  - LUI (0x0F): alu_op=SLL, operand1 = 16, operand2 = zero-extended imm.
  - LW (0x23): ADD with sign-extended imm; mem_read=1; reg_write=1.
  - SW (0x2B): ADD with sign-extended imm; mem_write=1; reg_write=0.
  - BEQ/BNE (0x04/0x05): SUB with operand2 = rt_data; branch_eq or branch_ne=1; reg_write=0.
- Any other opcode or funct: load a bubble with illegal=1 and ex_valid=0.
- store_data = rt_data for every instruction; it is only meaningful for SW.
- Sign extension is replication of instr[15] up to N bits. All immediates are extended to N, never truncated.

Decomposition:
- Shared package mips_defs_pkg holds:
  - the ALU op_code constants (ALU_SLL to ALU_SLT) used by both this block and the ALU;
  - opcode and funct localparams;
  - a ctrl_t struct {reg_write, mem_read, mem_write, branch_eq, branch_ne}.
- One natural sub-module: alu_decoder, purely combinational. It maps opcode/funct to alu_op, operand-select, immediate-extension mode, ctrl_t and illegal.
- id_ex_stage keeps the operand muxes and the register with its stall/flush logic.

Test Plan:
- Reset while the pipeline is loaded, then release rst_n with instr=ADD $3,$1,$2, rs=5, rt=7 → one cycle later: alu_op=3, operands 5/7, dest_reg=3, reg_write=1, ex_valid=1.
- SLL $4,$2,3 with rt=0x1 → alu_op=0, operand1=3, operand2=1. LUI $5,0xABCD → alu_op=0, operand1=16, operand2=0x0000ABCD.
- LW $6,-4($1) with rs=0x100 → alu_op=3, operand2=0xFFFFFFFC, mem_read=1. ANDI with imm=0x8000 → operand2=0x00008000.
- Load BEQ, then hold stall=1 for 3 cycles while instr changes → outputs stay frozen with branch_eq=1; stall=1 and flush=1 together → bubble with ex_valid=0.
- Opcode 0x3F → illegal=1 for one cycle, all control bits 0, ex_valid=0. instr_valid=0 → bubble with illegal=0.
- Drive rst_n low asynchronously mid-cycle while ex_valid=1 → all outputs 0 immediately, without waiting for a clock edge.
